// File: rtl/td4_pkg.sv
// Shared types for the TD4 run controller: FSM states, host command codes and halt causes.
// The cmd_legal helper gives the single table of which command is accepted in which state.
package td4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'd0,
        CMD_RUN  = 2'd1,
        CMD_STEP = 2'd2,
        CMD_HALT = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        HC_NONE = 2'd0,
        HC_CMD  = 2'd1,
        HC_STEP = 2'd2,
        HC_BP   = 2'd3
    } halt_cause_t;

    // Anything not listed here is flagged on cmd_err and leaves the state untouched.
    function automatic logic cmd_legal(state_t s, cmd_t c);
        case (s)
            ST_IDLE: return (c == CMD_LOAD) || (c == CMD_RUN);
            ST_LOAD: return c == CMD_HALT;
            ST_RUN:  return c == CMD_HALT;
            ST_STEP: return c == CMD_HALT;
            ST_HALT: return c != CMD_HALT;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/td4_run_ctrl_if.sv
// Host/debug side of the run controller: command channel, program-load channel and breakpoint setup.
// The host drives through master; the controller receives through slave.
interface td4_run_ctrl_if #(
    parameter int AW     = 4,
    parameter int DW     = 8,
    parameter int STEP_W = 8
);
    logic              cmd_valid;
    logic [1:0]        cmd;
    logic [STEP_W-1:0] cmd_arg;
    logic              ld_valid;
    logic              ld_ready;
    logic [AW-1:0]     ld_addr;
    logic [DW-1:0]     ld_data;
    logic              ld_last;
    logic              bp_en;
    logic [AW-1:0]     bp_addr;

    modport master (
        output cmd_valid, cmd, cmd_arg, ld_valid, ld_addr, ld_data, ld_last, bp_en, bp_addr,
        input  ld_ready
    );

    modport slave (
        input  cmd_valid, cmd, cmd_arg, ld_valid, ld_addr, ld_data, ld_last, bp_en, bp_addr,
        output ld_ready
    );
endinterface

// File: rtl/td4_prog_ram.sv
// Program store for the TD4 core: register array with one synchronous write port and an async read port.
// The reset clears every word, so a core reset-and-run without a reload fetches zeros.
module td4_prog_ram #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/td4_run_ctrl.sv
// Program-load and execution controller for the TD4 core: owns the program store and sequences
// the core through cpu_rstn / cpu_ce for load, free-run, N-step, halt and PC breakpoint.
module td4_run_ctrl
    import td4_pkg::*;
#(
    parameter int AW     = 4,
    parameter int DW     = 8,
    parameter int STEP_W = 8,
    parameter int CYC_W  = 16
) (
    input  logic             clk,
    input  logic             rstn,
    td4_run_ctrl_if.slave    host,
    input  logic [AW-1:0]    cpu_address,
    output logic [DW-1:0]    cpu_instr,
    output logic             cpu_rstn,
    output logic             cpu_ce,
    output logic [2:0]       state,
    output logic [1:0]       halt_cause,
    output logic             cmd_err,
    output logic [CYC_W-1:0] cyc_cnt
);
    state_t            state_q, state_next;
    halt_cause_t       halt_cause_q, cause_next;
    logic [STEP_W-1:0] step_cnt_q, step_next;
    logic              skip_bp_q;
    logic              legal, cmd_ok, err_next, bp_hit, ram_we;
    logic [DW-1:0]     ram_rdata;

    td4_prog_ram #(.AW(AW), .DW(DW)) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (ram_we),
        .waddr (host.ld_addr),
        .wdata (host.ld_data),
        .raddr (cpu_address),
        .rdata (ram_rdata)
    );

    // A legal command always takes priority over a breakpoint hit or step completion.
    always_comb begin
        state_next = state_q;
        cause_next = halt_cause_q;
        step_next  = step_cnt_q;
        cpu_ce     = 1'b0;
        ram_we     = 1'b0;
        legal      = cmd_legal(state_q, cmd_t'(host.cmd));
        cmd_ok     = host.cmd_valid && legal;
        err_next   = host.cmd_valid && !legal;
        bp_hit     = host.bp_en && (cpu_address == host.bp_addr) && !skip_bp_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_ok) state_next = (cmd_t'(host.cmd) == CMD_RUN) ? ST_RUN : ST_LOAD;
            end
            ST_LOAD: begin
                ram_we = host.ld_valid;
                if (cmd_ok || (host.ld_valid && host.ld_last)) state_next = ST_IDLE;
            end
            ST_RUN: begin
                cpu_ce = !bp_hit;
                if (cmd_ok) begin
                    state_next = ST_HALT;
                    cause_next = HC_CMD;
                end else if (bp_hit) begin
                    state_next = ST_HALT;
                    cause_next = HC_BP;
                end
            end
            ST_STEP: begin
                cpu_ce = (step_cnt_q != '0);
                if (step_cnt_q != '0) step_next = step_cnt_q - 1'b1;
                if (cmd_ok) begin
                    state_next = ST_HALT;
                    cause_next = HC_CMD;
                end else if (step_cnt_q == '0) begin
                    state_next = ST_HALT;
                    cause_next = HC_STEP;
                end
            end
            ST_HALT: begin
                if (cmd_ok) begin
                    cause_next = HC_NONE;
                    case (cmd_t'(host.cmd))
                        CMD_RUN:  state_next = ST_RUN;
                        CMD_LOAD: state_next = ST_LOAD;
                        CMD_STEP: begin
                            state_next = ST_STEP;
                            step_next  = host.cmd_arg;
                        end
                        default:  state_next = ST_HALT;
                    endcase
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // skip_bp lets a resume from HALT execute the instruction sitting on the breakpoint.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            halt_cause_q <= HC_NONE;
            step_cnt_q   <= '0;
            skip_bp_q    <= 1'b0;
            cpu_rstn     <= 1'b0;
            cmd_err      <= 1'b0;
            cyc_cnt      <= '0;
        end else begin
            state_q      <= state_next;
            halt_cause_q <= cause_next;
            step_cnt_q   <= step_next;
            skip_bp_q    <= (state_q == ST_HALT) && (state_next == ST_RUN);
            cpu_rstn     <= (state_next == ST_RUN) || (state_next == ST_STEP) || (state_next == ST_HALT);
            cmd_err      <= err_next;
            if ((state_q == ST_IDLE) && (state_next == ST_RUN)) begin
                cyc_cnt <= '0;
            end else if (cpu_ce && (cyc_cnt != '1)) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

    assign host.ld_ready = (state_q == ST_LOAD);
    assign cpu_instr     = (state_q == ST_LOAD) ? '0 : ram_rdata;
    assign state         = state_q;
    assign halt_cause    = halt_cause_q;
endmodule
